// File: rtl/pc_gen_if.sv
// Fetch-stage control/address bundle between the pipeline controller and pc_gen.
// master: pipeline side that requests stalls and redirects.
// slave:  pc_gen side that produces the fetch address.
interface pc_gen_if;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        pend_o;
  logic        addr_err_o;

  modport master (
    output stall_i, branch_flag_i, branch_target_i, flush_i, new_pc_i,
    input  pc_o, ce_o, pend_o, addr_err_o
  );

  modport slave (
    input  stall_i, branch_flag_i, branch_target_i, flush_i, new_pc_i,
    output pc_o, ce_o, pend_o, addr_err_o
  );
endinterface

// File: rtl/pc_gen.sv
// MIPS32 fetch-stage program-counter generator.
// Sequential increment, stall hold, branch/jump redirect with a one-entry
// pending buffer for branches that arrive during a stall, and flush redirect.
// Optional feature macro: ALIGN_CHECK_EN
//   defined   - misaligned redirect targets are dropped and pulse addr_err_o
//   undefined - target bits [1:0] are cleared and the redirect is taken
// All outputs are registered; reset is synchronous, active-low.
module pc_gen #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        ce_q, ce_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;

  // Redirect target qualification: "ok" says the target may be used,
  // "tgt" is the address actually loaded into the PC.
  logic        flush_ok, branch_ok;
  logic [31:0] flush_tgt, branch_tgt;

`ifdef ALIGN_CHECK_EN
  assign flush_ok   = (bus.new_pc_i[1:0] == 2'b00);
  assign branch_ok  = (bus.branch_target_i[1:0] == 2'b00);
  assign flush_tgt  = bus.new_pc_i;
  assign branch_tgt = bus.branch_target_i;
`else
  assign flush_ok   = 1'b1;
  assign branch_ok  = 1'b1;
  assign flush_tgt  = bus.new_pc_i & 32'hFFFF_FFFC;
  assign branch_tgt = bus.branch_target_i & 32'hFFFF_FFFC;
`endif

  // A rejected redirect behaves as if it had not been requested; the error
  // pulse is only raised for a request that priority would have honoured.
  logic flush_take, branch_take, bad_redirect;
  assign flush_take   = bus.flush_i && flush_ok;
  assign branch_take  = bus.branch_flag_i && branch_ok;
  assign bad_redirect = (bus.flush_i && !flush_ok) ||
                        (!flush_take && bus.branch_flag_i && !branch_ok);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE lasts exactly one cycle after reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next-value logic for the registered outputs, in redirect priority order.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    ce_d       = ce_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        ce_d = 1'b1;
      end
      RUN: begin
        ce_d  = 1'b1;
        err_d = bad_redirect;
        if (flush_take) begin
          pc_d   = flush_tgt;
          pend_d = 1'b0;
        end else if (bus.stall_i) begin
          if (branch_take) begin
            pend_tgt_d = branch_tgt;
            pend_d     = 1'b1;
          end
        end else if (branch_take) begin
          pc_d   = branch_tgt;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  // Output/datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      pend_tgt_q <= 32'h0000_0000;
      ce_q       <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      ce_q       <= ce_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.ce_o       = ce_q;
  assign bus.pend_o     = pend_q;
  assign bus.addr_err_o = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected outputs are queued when stimulus
// is applied and popped/compared after the next rising edge.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        flush;
    logic [31:0] npc;
  } stim_t;

  logic clk;
  logic rst_n;
  pc_gen_if bus ();

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  pc_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the outputs the spec requires after the edge.
  task automatic drive(input stim_t s, input exp_t e);
    rst_n               = s.rst_n;
    bus.stall_i         = s.stall;
    bus.branch_flag_i   = s.br;
    bus.branch_target_i = s.tgt;
    bus.flush_i         = s.flush;
    bus.new_pc_i        = s.npc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t observe();
    return '{pc: bus.pc_o, ce: bus.ce_o, pend: bus.pend_o, err: bus.addr_err_o};
  endfunction

  // Stimulus shorthands: run, stall, branch, flush.
  function automatic stim_t s_run();
    return '{rst_n: 1'b1, stall: 1'b0, br: 1'b0, tgt: 32'h0, flush: 1'b0, npc: 32'h0};
  endfunction
  function automatic stim_t s_sb(input logic st, input logic br, input logic [31:0] tgt);
    return '{rst_n: 1'b1, stall: st, br: br, tgt: tgt, flush: 1'b0, npc: 32'h0};
  endfunction
  function automatic exp_t ex(input logic [31:0] pc, input logic ce, input logic pend, input logic err);
    return '{pc: pc, ce: ce, pend: pend, err: err};
  endfunction

  task automatic test_reset();
    stim_t s [6];
    exp_t  e [6];
    exp_t  o, x;
    s[0] = s_run(); s[0].rst_n = 1'b0; e[0] = ex(32'h0, 1'b0, 1'b0, 1'b0);
    s[1] = s[0];                       e[1] = ex(32'h0, 1'b0, 1'b0, 1'b0);
    s[2] = s_run();                    e[2] = ex(32'h0, 1'b1, 1'b0, 1'b0);
    s[3] = s_run();                    e[3] = ex(32'h4, 1'b1, 1'b0, 1'b0);
    s[4] = s_run();                    e[4] = ex(32'h8, 1'b1, 1'b0, 1'b0);
    s[5] = s_run();                    e[5] = ex(32'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL reset[%0d] got pc=%h ce=%b pend=%b err=%b want pc=%h ce=%b pend=%b err=%b",
                 i, o.pc, o.ce, o.pend, o.err, x.pc, x.ce, x.pend, x.err);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s [5];
    exp_t  e [5];
    exp_t  o, x;
    s[0] = s_run();                   e[0] = ex(32'h10, 1'b1, 1'b0, 1'b0);
    s[1] = s_sb(1'b1, 1'b0, 32'h0);   e[1] = ex(32'h10, 1'b1, 1'b0, 1'b0);
    s[2] = s[1];                      e[2] = e[1];
    s[3] = s[1];                      e[3] = e[1];
    s[4] = s_run();                   e[4] = ex(32'h14, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL stall[%0d] got pc=%h pend=%b want pc=%h pend=%b", i, o.pc, o.pend, x.pc, x.pend);
      end
    end
  endtask

  task automatic test_pending_branch();
    stim_t s [12];
    exp_t  e [12];
    exp_t  o, x;
    // Basic deferral.
    s[0]  = s_sb(1'b1, 1'b1, 32'h100); e[0]  = ex(32'h14,  1'b1, 1'b1, 1'b0);
    s[1]  = s_sb(1'b1, 1'b0, 32'h0);   e[1]  = ex(32'h14,  1'b1, 1'b1, 1'b0);
    s[2]  = s_run();                   e[2]  = ex(32'h100, 1'b1, 1'b0, 1'b0);
    s[3]  = s_run();                   e[3]  = ex(32'h104, 1'b1, 1'b0, 1'b0);
    // Newer branch overwrites the buffered one.
    s[4]  = s_sb(1'b1, 1'b1, 32'h140); e[4]  = ex(32'h104, 1'b1, 1'b1, 1'b0);
    s[5]  = s_sb(1'b1, 1'b1, 32'h160); e[5]  = ex(32'h104, 1'b1, 1'b1, 1'b0);
    s[6]  = s_run();                   e[6]  = ex(32'h160, 1'b1, 1'b0, 1'b0);
    s[7]  = s_run();                   e[7]  = ex(32'h164, 1'b1, 1'b0, 1'b0);
    // Live branch beats the pending one, which is then dropped.
    s[8]  = s_sb(1'b1, 1'b1, 32'h1C0); e[8]  = ex(32'h164, 1'b1, 1'b1, 1'b0);
    s[9]  = s_sb(1'b0, 1'b1, 32'h1E0); e[9]  = ex(32'h1E0, 1'b1, 1'b0, 1'b0);
    s[10] = s_run();                   e[10] = ex(32'h1E4, 1'b1, 1'b0, 1'b0);
    s[11] = s_run();                   e[11] = ex(32'h1E8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL pending[%0d] got pc=%h pend=%b want pc=%h pend=%b", i, o.pc, o.pend, x.pc, x.pend);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s [5];
    exp_t  e [5];
    exp_t  o, x;
    s[0] = s_sb(1'b1, 1'b1, 32'h100);  e[0] = ex(32'h1E8, 1'b1, 1'b1, 1'b0);
    // Flush wins over stall and over a simultaneous branch.
    s[1] = s_sb(1'b1, 1'b1, 32'h300);
    s[1].flush = 1'b1; s[1].npc = 32'h180; e[1] = ex(32'h180, 1'b1, 1'b0, 1'b0);
    s[2] = s_sb(1'b1, 1'b0, 32'h0);    e[2] = ex(32'h180, 1'b1, 1'b0, 1'b0);
    s[3] = s_run();                    e[3] = ex(32'h184, 1'b1, 1'b0, 1'b0);
    // Flush in a non-stalled cycle with a misaligned vector.
    s[4] = s_run(); s[4].flush = 1'b1; s[4].npc = 32'h0000_0281;
`ifdef ALIGN_CHECK_EN
    e[4] = ex(32'h188, 1'b1, 1'b0, 1'b1);
`else
    e[4] = ex(32'h280, 1'b1, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL flush[%0d] got pc=%h pend=%b err=%b want pc=%h pend=%b err=%b",
                 i, o.pc, o.pend, o.err, x.pc, x.pend, x.err);
      end
    end
  endtask

  task automatic test_wrap_and_align();
    stim_t s [5];
    exp_t  e [5];
    exp_t  o, x;
    s[0] = s_sb(1'b0, 1'b1, 32'hFFFF_FFFC); e[0] = ex(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    s[1] = s_run();                         e[1] = ex(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    s[2] = s_run();                         e[2] = ex(32'h0000_0004, 1'b1, 1'b0, 1'b0);
    s[3] = s_sb(1'b0, 1'b1, 32'h202);
`ifdef ALIGN_CHECK_EN
    e[3] = ex(32'h8, 1'b1, 1'b0, 1'b1);
    s[4] = s_run(); e[4] = ex(32'hC, 1'b1, 1'b0, 1'b0);
`else
    e[3] = ex(32'h200, 1'b1, 1'b0, 1'b0);
    s[4] = s_run(); e[4] = ex(32'h204, 1'b1, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL wrap_align[%0d] got pc=%h err=%b want pc=%h err=%b", i, o.pc, o.err, x.pc, x.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s [5];
    exp_t  e [5];
    exp_t  o, x;
    logic [31:0] base;
`ifdef ALIGN_CHECK_EN
    base = 32'hC;
`else
    base = 32'h204;
`endif
    s[0] = s_sb(1'b1, 1'b1, 32'h400); e[0] = ex(base, 1'b1, 1'b1, 1'b0);
    // Reset wins over flush and stall at the same edge.
    s[1] = s_sb(1'b1, 1'b0, 32'h0); s[1].rst_n = 1'b0; s[1].flush = 1'b1; s[1].npc = 32'h500;
    e[1] = ex(32'h0, 1'b0, 1'b0, 1'b0);
    // IDLE ignores a live branch.
    s[2] = s_sb(1'b0, 1'b1, 32'h600); e[2] = ex(32'h0, 1'b1, 1'b0, 1'b0);
    // Pending target was discarded by reset: plain increment follows.
    s[3] = s_run();                   e[3] = ex(32'h4, 1'b1, 1'b0, 1'b0);
    s[4] = s_run();                   e[4] = ex(32'h8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      o = observe(); x = sb.pop_front(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL reset_mid[%0d] got pc=%h ce=%b pend=%b want pc=%h ce=%b pend=%b",
                 i, o.pc, o.ce, o.pend, x.pc, x.ce, x.pend);
      end
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.flush_i         = 1'b0;
    bus.new_pc_i        = 32'h0;
    test_reset();
    test_stall();
    test_pending_branch();
    test_flush();
    test_wrap_and_align();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
